// File: rtl/clock_ena_seq.sv
// Clock-enable sequencer for a regional clock buffer: waits for a stable PLL/MMCM lock before enabling.
// Optional WAIT_LOCK timeout and FAULT state are built when CLOCK_ENA_TIMEOUT_EN is defined.
module clock_ena_seq #(
  parameter int SETTLE_CYCLES = 256,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int CNT_W         = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       locked,
  output logic       ena,
  output logic       ready,
  output logic       lost_lock,
  output logic       fault,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam int               CNT_MAX_I   = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX_I);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef CLOCK_ENA_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
`endif

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic             sync_1, locked_s;
  logic             lost_lock_next;

  // Two-flop synchronizer for the asynchronous lock flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_1   <= locked;
      locked_s <= sync_1;
    end
  end

  // Saturating increment; never wraps even if the width rule is violated.
  assign cnt_inc = (cnt < CNT_SAT) ? cnt + 1'b1 : cnt;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!req) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_next = S_SETTLE;
            cnt_next   = '0;
          end else begin
`ifdef CLOCK_ENA_TIMEOUT_EN
            if (cnt == LOCK_LAST) begin
              state_next = S_FAULT;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_inc;
            end
`else
            cnt_next = '0;
`endif
          end
        end
        S_SETTLE: begin
          if (!locked_s) begin
            state_next = S_WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt == SETTLE_LAST) begin
            state_next = S_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_next = S_WAIT_LOCK;
            cnt_next   = '0;
          end
        end
        S_FAULT: begin
`ifndef CLOCK_ENA_TIMEOUT_EN
          state_next = S_IDLE;
          cnt_next   = '0;
`endif
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Sticky loss flag: set only by a lock drop seen while running, cleared by withdrawing req.
  assign lost_lock_next = req & (lost_lock | ((state == S_RUN) & ~locked_s));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ena       <= 1'b0;
      ready     <= 1'b0;
      lost_lock <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      ena       <= (state_next == S_RUN);
      ready     <= (state_next == S_RUN);
      lost_lock <= lost_lock_next;
`ifdef CLOCK_ENA_TIMEOUT_EN
      fault     <= (state_next == S_FAULT);
`else
      fault     <= 1'b0;
`endif
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_clock_ena_seq.sv
// Directed bench for clock_ena_seq with SETTLE_CYCLES=16, LOCK_TIMEOUT=100.
// Expectations follow CLOCK_ENA_TIMEOUT_EN when it is defined for the compile.
module tb_clock_ena_seq;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  logic       clk = 1'b0;
  logic       rst, req, locked;
  logic       ena, ready, lost_lock, fault;
  logic [2:0] state_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;

  clock_ena_seq #(
    .SETTLE_CYCLES(16),
    .LOCK_TIMEOUT (100),
    .CNT_W        (17)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .locked   (locked),
    .ena      (ena),
    .ready    (ready),
    .lost_lock(lost_lock),
    .fault    (fault),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // one active edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // edge 0 samples locked=1; expect ena low through edge 17 and high at edge 18
  task automatic lock_to_run(input string tag, input logic exp_lost);
    logic early;
    early = 1'b0;
    locked = 1'b1;
    tick();
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (ena !== 1'b0) early = 1'b1;
    end
    chk({tag, "_no_early_ena"}, {31'd0, early}, 32'd0);
    tick();
    chk({tag, "_ena"}, {31'd0, ena}, 32'd1);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_lost"}, {31'd0, lost_lock}, {31'd0, exp_lost});
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin
    logic bad;
    int   n;
    rst = 1'b1; req = 1'b0; locked = 1'b0;
    repeat (3) tick();
    chk("rst_ena", {31'd0, ena}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_lost", {31'd0, lost_lock}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    rst = 1'b0;

    // nominal bring-up
    req = 1'b1;
    tick();
    chk("nom_wait", {29'd0, state_dbg}, {29'd0, ST_WAIT});
    lock_to_run("nom", 1'b0);

    // lock loss in RUN: locked=0 sampled at edge m, ena falls at m+2
    locked = 1'b0;
    tick();
    chk("loss_m0_ena", {31'd0, ena}, 32'd1);
    tick();
    chk("loss_m1_ena", {31'd0, ena}, 32'd1);
    tick();
    chk("loss_m2_ena", {31'd0, ena}, 32'd0);
    chk("loss_m2_lost", {31'd0, lost_lock}, 32'd1);
    chk("loss_m2_state", {29'd0, state_dbg}, {29'd0, ST_WAIT});
    lock_to_run("relock", 1'b1);

    // one-cycle req pulse clears lost_lock
    req = 1'b0;
    tick();
    chk("pulse_ena", {31'd0, ena}, 32'd0);
    chk("pulse_lost", {31'd0, lost_lock}, 32'd0);
    chk("pulse_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    req = 1'b1;
    tick();
    chk("rereq_wait", {29'd0, state_dbg}, {29'd0, ST_WAIT});
    // lock already stable: ena rises 17 edges after the edge sampling req
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ena !== 1'b0) bad = 1'b1;
    end
    chk("rereq_no_early", {31'd0, bad}, 32'd0);
    tick();
    chk("rereq_ena", {31'd0, ena}, 32'd1);

    // lock bounce during settle
    req = 1'b0; locked = 1'b0;
    repeat (3) tick();
    req = 1'b1;
    tick();
    locked = 1'b1;
    tick();
    repeat (12) tick();
    chk("bounce_settle", {29'd0, state_dbg}, {29'd0, ST_SETTLE});
    locked = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ena !== 1'b0 || lost_lock !== 1'b0) bad = 1'b1;
    end
    chk("bounce_low", {31'd0, bad}, 32'd0);
    lock_to_run("bounce", 1'b0);

    // reset mid-RUN drops everything at that edge
    rst = 1'b1;
    tick();
    chk("mid_rst_ena", {31'd0, ena}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    rst = 1'b0;
    n = 0;
    while (ena !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("rearm_edges", n, 32'd19);

    // req withdrawal in RUN
    req = 1'b0;
    tick();
    chk("wd_ena", {31'd0, ena}, 32'd0);
    chk("wd_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});

    // req=0 beats lock recovery in the same cycle
    req = 1'b1;
    repeat (18) tick();
    chk("race_run", {31'd0, ena}, 32'd1);
    locked = 1'b0;
    repeat (3) tick();
    chk("race_lost", {31'd0, lost_lock}, 32'd1);
    locked = 1'b1;
    repeat (1) tick();
    req = 1'b0;
    tick();
    chk("race_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    chk("race_lost_clr", {31'd0, lost_lock}, 32'd0);
    chk("race_ena", {31'd0, ena}, 32'd0);

    // timeout
    locked = 1'b0;
    repeat (3) tick();
    req = 1'b1;
    tick();
`ifdef CLOCK_ENA_TIMEOUT_EN
    bad = 1'b0;
    for (int i = 1; i < 100; i++) begin
      tick();
      if (fault !== 1'b0) bad = 1'b1;
    end
    chk("to_no_early", {31'd0, bad}, 32'd0);
    tick();
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_state", {29'd0, state_dbg}, {29'd0, ST_FAULT});
    locked = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (fault !== 1'b1 || ena !== 1'b0) bad = 1'b1;
    end
    chk("to_stuck", {31'd0, bad}, 32'd0);
    req = 1'b0;
    tick();
    chk("to_clr_fault", {31'd0, fault}, 32'd0);
    chk("to_clr_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
`else
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (fault !== 1'b0) bad = 1'b1;
    end
    chk("nto_no_fault", {31'd0, bad}, 32'd0);
    chk("nto_state", {29'd0, state_dbg}, {29'd0, ST_WAIT});
    lock_to_run("nto", 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/clock_ena_seq.md
# clock_ena_seq

Clock-enable sequencer that drives the `ena` input of a downstream regional clock buffer (the BUFR-type `clock_buf` stage). It runs on a free-running reference clock and watches the `locked` flag of an MMCM/PLL. The buffered clock is enabled only after lock has been stable for a programmable settle time. The buffer is disabled as soon as lock is lost or software withdraws its request.

## Interface

Parameters:
- `SETTLE_CYCLES`, 256: number of consecutive cycles with synchronized lock held before `ena` asserts; minimum 1.
- `LOCK_TIMEOUT`, 65536: maximum cycles spent in WAIT_LOCK before fault; minimum 1; used only with `CLOCK_ENA_TIMEOUT_EN`.
- `CNT_W`, 17: counter width; must satisfy 2^CNT_W > max(SETTLE_CYCLES, LOCK_TIMEOUT).

Ports:
- `clk`, in, 1: free-running reference clock; never the buffered clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, 1: enable request, synchronous to `clk`.
- `locked`, in, 1: MMCM/PLL lock, asynchronous; passes through a 2-flop synchronizer to give `locked_s`.
- `ena`, out, 1: clock enable to the downstream `clock_buf`.
- `ready`, out, 1: buffered clock is running; identical to `ena`.
- `lost_lock`, out, 1: sticky flag; lock dropped while in RUN.
- `fault`, out, 1: lock timeout. Constant 0 when the timeout feature is compiled out.

## Operation

- Reset values: state IDLE, counter 0, synchronizer flops 0, and `ena`/`ready`/`lost_lock`/`fault` all 0.
- All outputs are registered. `ena` is decoded from next-state, so it is high in the first RUN cycle.
- The `req=0` check has top priority in every state: the next state is IDLE, `lost_lock` and `fault` clear, and the counter clears.
- IDLE: when `req=1`, go to WAIT_LOCK with counter 0.
- WAIT_LOCK:
  - If `locked_s=1`, go to SETTLE with counter 0.
  - Otherwise the counter increments (timeout builds only).
  - If counter == LOCK_TIMEOUT-1 and `locked_s=0`, go to FAULT.
  - Lock wins over timeout when both occur in the same cycle.
- SETTLE:
  - If `locked_s=0`, return to WAIT_LOCK with counter 0. `lost_lock` is not set.
  - If counter == SETTLE_CYCLES-1, go to RUN.
  - Otherwise the counter increments.
- RUN: `ena=ready=1`. If `locked_s=0`, go to WAIT_LOCK with counter 0 and set `lost_lock=1`.
- FAULT: `ena=0`, `fault=1`. The only exit is `req=0`, which goes to IDLE.
- The counter saturates and never wraps; with the width rule above, wrap cannot occur.
- Asserting `rst` mid-RUN drops `ena` at that edge. There is no drain or hold-off.

## Timing

- Call the edge that first samples `locked=1` into the synchronizer edge 0.
  - `locked_s` is high after edge 1.
  - The state becomes SETTLE at edge 2.
  - `ena` rises at edge SETTLE_CYCLES+2.
  - This assumes `req=1` and the state is already WAIT_LOCK.
- Lock loss: if `locked=0` is first sampled at edge m, `ena` falls at edge m+2.
- `req` falling at edge r makes `ena` fall at edge r. `req` is not synchronized.
- IDLE to WAIT_LOCK takes 1 cycle after `req` rises. If lock is already stable, `ena` rises SETTLE_CYCLES+1 edges after the edge that samples `req=1`.
- Timeout: entering WAIT_LOCK at edge e with lock absent asserts `fault` at edge e+LOCK_TIMEOUT.
- A `locked` glitch narrower than one `clk` period may be missed. This is accepted behaviour.

## Configuration

- `CLOCK_ENA_TIMEOUT_EN` defined:
  - The WAIT_LOCK timeout counter and the FAULT state are built.
  - `fault` is driven as described in Operation.
- Not defined:
  - WAIT_LOCK waits indefinitely, and the FAULT state is unreachable and removed.
  - `fault` is tied to 0.
  - The counter is used only for SETTLE.

## Test plan

Bench settings: SETTLE_CYCLES=16, LOCK_TIMEOUT=100, macro defined unless noted.

- Nominal bring-up: hold `req=1`, then raise `locked` sampled at edge 0.
  - Required: `ena=ready=1` at edge 18 and not before; `lost_lock=fault=0`.
- Lock bounce during settle: drop `locked` for 3 cycles at settle count 10.
  - Required: `ena` stays 0 and `lost_lock=0`.
  - After lock returns, a full 16-cycle settle restarts; `ena` rises 18 edges after lock is re-sampled.
- Lock loss in RUN: drop `locked` at edge m.
  - Required: `ena=0` at edge m+2 and `lost_lock=1` sticky.
  - After lock returns, `ena` re-asserts after 18 edges with `lost_lock` still 1.
  - Pulsing `req=0` for one cycle clears `lost_lock`.
- Timeout: set `req=1` with `locked=0` held.
  - Required: `fault=1` exactly 100 edges after WAIT_LOCK entry.
  - Raising `locked` afterwards has no effect; `req=0` returns to IDLE with `fault=0`.
  - With the macro undefined, the same stimulus leaves `fault=0` for 1000 cycles and `ena` still rises 18 edges after lock.
- Reset and request withdrawal mid-RUN:
  - `rst=1` in RUN gives all outputs 0 at that edge.
  - `req=0` in RUN gives `ena=0` at that edge and state IDLE.
  - When `req` and lock-recovery arrive in the same cycle, `req=0` wins.
